// File: rtl/axi_pkg.sv
// Shared AXI bridge types: slave-select codes, write phases, address map.
// Width macros AXI_ADDR_BITS / AXI_LEN_BITS default here if not set elsewhere.
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif

package axi_pkg;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] AW_M1_S0 = 2'd1;
    localparam logic [1:0] AW_M1_S1 = 2'd2;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_AW   = 2'd1,
        PH_W    = 2'd2,
        PH_B    = 2'd3
    } w_phase_t;

    localparam logic [15:0] S0_BASE = 16'h0000;
    localparam logic [15:0] S1_BASE = 16'h0001;

endpackage

// File: rtl/wr_watchdog.sv
// Stall counter for write phases; flags expiry when a phase sits idle
// TIMEOUT_CYCLES cycles without a handshake. Used only under WR_TIMEOUT_EN.
module wr_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic ACLK,
    input  logic ARESETn,
    input  logic active,
    input  logic clr,
    input  logic hs,
    output logic expire
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wd_q <= '0;
        end else if (clr || !active) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + WD_W'(1);
        end
    end

    // A handshake in the expiry cycle keeps the transaction alive.
    assign expire = active && !hs &&
                    (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/write_state_ctrl.sv
// M1 write controller: grants S0/S1 and tracks AW/W/B phases of one burst.
// Optional watchdog abort enabled with `define WR_TIMEOUT_EN.
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif

module write_state_ctrl
  import axi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic                      AWVALID_M1,
  input  logic [`AXI_ADDR_BITS-1:0] AWADDR_M1,
  input  logic [`AXI_LEN_BITS-1:0]  AWLEN_M1,
  input  logic                      AWREADY_S0,
  input  logic                      AWREADY_S1,
  input  logic                      WVALID_M1,
  input  logic                      WLAST_M1,
  input  logic                      WREADY_S0,
  input  logic                      WREADY_S1,
  input  logic                      BVALID_S0,
  input  logic                      BVALID_S1,
  input  logic                      BREADY_M1,
  output logic [1:0]                W_state,
`ifdef WR_TIMEOUT_EN
  output logic                      timeout_err,
`endif
  output logic [1:0]                W_phase,
  output logic                      wlast_err
);

  logic [1:0]               state_q, state_n;
  w_phase_t                 phase_q, phase_n;
  logic [`AXI_LEN_BITS-1:0] cnt_q, cnt_n;
  logic [`AXI_LEN_BITS-1:0] len_q, len_n;
  logic                     werr_q, werr_n;

  logic        aw_rdy, w_rdy, b_vld;
  logic        aw_hs, w_hs, b_hs, hs;
  logic        last_beat;
  logic [15:0] aw_base;
  logic        unused_addr;

  assign aw_base     = AWADDR_M1[31:16];
  assign unused_addr = ^AWADDR_M1[15:0];

  always_comb begin
    aw_rdy = 1'b0;
    w_rdy  = 1'b0;
    b_vld  = 1'b0;
    unique case (1'b1)
      state_q == AW_M1_S0: begin
        aw_rdy = AWREADY_S0;
        w_rdy  = WREADY_S0;
        b_vld  = BVALID_S0;
      end
      state_q == AW_M1_S1: begin
        aw_rdy = AWREADY_S1;
        w_rdy  = WREADY_S1;
        b_vld  = BVALID_S1;
      end
      default: ;
    endcase
    aw_hs = (phase_q == PH_AW) && AWVALID_M1 && aw_rdy;
    w_hs  = (phase_q == PH_W) && WVALID_M1 && w_rdy;
    b_hs  = (phase_q == PH_B) && b_vld && BREADY_M1;
    hs    = aw_hs || w_hs || b_hs;
  end

  assign last_beat = (cnt_q == len_q);

`ifdef WR_TIMEOUT_EN
  logic wd_expire;
  logic wd_clr;
  logic tmo_q;

  assign wd_clr = hs || (phase_n != phase_q);

  wr_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .ACLK   (ACLK),
    .ARESETn(ARESETn),
    .active (phase_q != PH_IDLE),
    .clr    (wd_clr),
    .hs     (hs),
    .expire (wd_expire)
  );
`endif

  always_comb begin
    state_n = state_q;
    phase_n = phase_q;
    cnt_n   = cnt_q;
    len_n   = len_q;
    werr_n  = 1'b0;
    unique case (phase_q)
      PH_IDLE: begin
        if (AWVALID_M1) begin
          unique case (1'b1)
            aw_base == S0_BASE: begin
              state_n = AW_M1_S0;
              phase_n = PH_AW;
            end
            aw_base == S1_BASE: begin
              state_n = AW_M1_S1;
              phase_n = PH_AW;
            end
            default: ;
          endcase
        end
      end
      PH_AW: begin
        if (aw_hs) begin
          len_n   = AWLEN_M1;
          cnt_n   = '0;
          phase_n = PH_W;
        end
      end
      PH_W: begin
        if (w_hs) begin
          if (WLAST_M1 || last_beat) begin
            phase_n = PH_B;
            werr_n  = WLAST_M1 ^ last_beat;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
      end
      PH_B: begin
        if (b_hs) begin
          state_n = IDLE;
          phase_n = PH_IDLE;
        end
      end
      default: ;
    endcase
`ifdef WR_TIMEOUT_EN
    if (wd_expire) begin
      state_n = IDLE;
      phase_n = PH_IDLE;
    end
`endif
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      werr_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      phase_q <= phase_n;
      cnt_q   <= cnt_n;
      len_q   <= len_n;
      werr_q  <= werr_n;
    end
  end

`ifdef WR_TIMEOUT_EN
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= wd_expire;
    end
  end

  assign timeout_err = tmo_q;
`endif

  assign W_state   = state_q;
  assign W_phase   = phase_q;
  assign wlast_err = werr_q;

endmodule

// File: tb/tb_write_state_ctrl.sv
// Randomized scoreboard bench for write_state_ctrl against a transaction
// model; timeout scenarios are exercised when WR_TIMEOUT_EN is defined.
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif

module tb_write_state_ctrl;

  localparam int TMO = 16;

  logic                      ACLK = 1'b0;
  logic                      ARESETn;
  logic                      AWVALID_M1;
  logic [`AXI_ADDR_BITS-1:0] AWADDR_M1;
  logic [`AXI_LEN_BITS-1:0]  AWLEN_M1;
  logic                      AWREADY_S0, AWREADY_S1;
  logic                      WVALID_M1, WLAST_M1;
  logic                      WREADY_S0, WREADY_S1;
  logic                      BVALID_S0, BVALID_S1, BREADY_M1;
  logic [1:0]                W_state, W_phase;
  logic                      wlast_err;
  logic                      timeout_err;

  always #5 ACLK = ~ACLK;

  write_state_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .AWVALID_M1 (AWVALID_M1),
    .AWADDR_M1  (AWADDR_M1),
    .AWLEN_M1   (AWLEN_M1),
    .AWREADY_S0 (AWREADY_S0),
    .AWREADY_S1 (AWREADY_S1),
    .WVALID_M1  (WVALID_M1),
    .WLAST_M1   (WLAST_M1),
    .WREADY_S0  (WREADY_S0),
    .WREADY_S1  (WREADY_S1),
    .BVALID_S0  (BVALID_S0),
    .BVALID_S1  (BVALID_S1),
    .BREADY_M1  (BREADY_M1),
    .W_state    (W_state),
`ifdef WR_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .W_phase    (W_phase),
    .wlast_err  (wlast_err)
  );

`ifndef WR_TIMEOUT_EN
  assign timeout_err = 1'b0;
`endif

  typedef struct {
    int st;
    int ph;
    bit werr;
    bit terr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int m_slv = 0, m_ph = 0, m_beats = 0, m_len = 0, m_stall = 0;
  bit m_werr = 0, m_terr = 0;

  function automatic bit pick(bit a, bit b);
    return (m_slv == 1) ? a : b;
  endfunction

  function automatic void model_step();
    int  top;
    bit  hs;
    int  old_ph;
    bit  final_beat;
    m_werr = 0;
    m_terr = 0;
    if (!ARESETn) begin
      m_slv = 0; m_ph = 0; m_beats = 0;
      m_len = 0; m_stall = 0;
      return;
    end
    hs = 0;
    old_ph = m_ph;
    top = int'(AWADDR_M1[31:16]);
    if (m_ph == 0) begin
      if (AWVALID_M1 && (top == 0 || top == 1)) begin
        m_slv = top + 1;
        m_ph = 1;
      end
    end else if (m_ph == 1) begin
      if (AWVALID_M1 && pick(AWREADY_S0, AWREADY_S1)) begin
        hs = 1;
        m_len = int'(AWLEN_M1);
        m_beats = 0;
        m_ph = 2;
      end
    end else if (m_ph == 2) begin
      if (WVALID_M1 && pick(WREADY_S0, WREADY_S1)) begin
        hs = 1;
        final_beat = (m_beats == m_len);
        if (WLAST_M1 || final_beat) begin
          m_ph = 3;
          m_werr = (WLAST_M1 != final_beat);
        end
        m_beats++;
      end
    end else begin
      if (pick(BVALID_S0, BVALID_S1) && BREADY_M1) begin
        hs = 1;
        m_ph = 0;
        m_slv = 0;
      end
    end
`ifdef WR_TIMEOUT_EN
    if (old_ph != 0 && !hs && m_stall + 1 == TMO) begin
      m_ph = 0;
      m_slv = 0;
      m_terr = 1;
    end
    if (old_ph == 0 || hs || m_ph != old_ph) m_stall = 0;
    else m_stall++;
`endif
  endfunction

  task automatic tick();
    exp_t e;
    model_step();
    e.st = m_slv;
    e.ph = m_ph;
    e.werr = m_werr;
    e.terr = m_terr;
    exp_q.push_back(e);
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge ACLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (int'(W_state) != e.st || int'(W_phase) != e.ph ||
            wlast_err != e.werr || timeout_err != e.terr) begin
          errors++;
          $display("FAIL outputs @%0t: st/ph/werr/terr got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                   $time, W_state, W_phase, wlast_err,
                   timeout_err, e.st, e.ph, e.werr, e.terr);
        end
      end
    end
  end

  function automatic bit rnd(int pct);
    return ($urandom_range(99) < pct);
  endfunction

  task automatic idle_inputs();
    AWVALID_M1 = 0; AWADDR_M1 = '0; AWLEN_M1 = '0;
    AWREADY_S0 = 0; AWREADY_S1 = 0;
    WVALID_M1 = 0; WLAST_M1 = 0;
    WREADY_S0 = 0; WREADY_S1 = 0;
    BVALID_S0 = 0; BVALID_S1 = 0; BREADY_M1 = 0;
  endtask

  task automatic run_txn(input logic [31:0] addr, input int len,
                         input int wl_beat, input int rdy,
                         input int bpct, input int rst_beat);
    int  top = int'(addr[31:16]);
    bit  sel0 = (top == 0);
    bit  started = 0;
    bit  rst_done = 0;
    int  n = 0;
    while (1) begin
      idle_inputs();
      ARESETn = 1;
      AWADDR_M1 = addr;
      AWLEN_M1 = `AXI_LEN_BITS'(len);
      AWVALID_M1 = (m_ph <= 1);
      AWREADY_S0 = sel0 ? rnd(rdy) : rnd(50);
      AWREADY_S1 = sel0 ? rnd(50) : rnd(rdy);
      WREADY_S0 = sel0 ? rnd(rdy) : rnd(50);
      WREADY_S1 = sel0 ? rnd(50) : rnd(rdy);
      BVALID_S0 = sel0 ? rnd(bpct) : rnd(50);
      BVALID_S1 = sel0 ? rnd(50) : rnd(bpct);
      BREADY_M1 = rnd(rdy);
      if (m_ph == 2) begin
        WVALID_M1 = rnd(rdy);
        WLAST_M1 = (m_beats + 1 == wl_beat);
      end else begin
        WVALID_M1 = rnd(30);
        WLAST_M1 = rnd(30);
      end
      if (rst_beat >= 0 && !rst_done && m_ph == 2 &&
          m_beats == rst_beat) begin
        ARESETn = 0;
        rst_done = 1;
      end
      if (m_ph != 0) started = 1;
      tick();
      n++;
      if (top > 1 && n >= 10) break;
      if (started && m_ph == 0) break;
      if (n > 400) begin
        errors++;
        $display("FAIL txn_bound: addr %h did not finish in 400 cycles", addr);
        break;
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    int len;
    int wl;
    logic [31:0] a;
    idle_inputs();
    ARESETn = 0;
    @(negedge ACLK);
    repeat (3) tick();
    ARESETn = 1;
    repeat (2) tick();

    run_txn(32'h0000_0100, 3, 4, 100, 100, -1);
    run_txn(32'h0001_0040, 0, 1, 100, 100, -1);
    run_txn(32'h0000_0200, 3, 2, 100, 100, -1);
    run_txn(32'h0001_0000, 2, 0, 100, 100, -1);
    run_txn(32'h0002_0000, 1, 2, 100, 100, -1);
    run_txn(32'h0000_0300, 3, 4, 100, 100, 2);
    run_txn(32'h0001_0300, 15, 16, 100, 100, -1);
    run_txn(32'h0000_0000, 0, 1, 100, 100, -1);
`ifdef WR_TIMEOUT_EN
    run_txn(32'h0000_0400, 1, 2, 100, 0, -1);
    run_txn(32'h0001_0400, 2, 3, 100, 0, -1);
    run_txn(32'h0000_0500, 4, 5, 5, 100, -1);
`endif

    for (int i = 0; i < 60; i++) begin
      a = $urandom();
      a[31:16] = ($urandom_range(7) == 0) ? 16'h0002
                                          : 16'($urandom_range(1));
      len = $urandom_range(15);
      wl = ($urandom_range(3) == 0) ? $urandom_range(16) : len + 1;
      run_txn(a, len, wl, 40 + $urandom_range(60),
              30 + $urandom_range(70),
              ($urandom_range(9) == 0) ? $urandom_range(len) : -1);
    end

    repeat (3) @(posedge ACLK);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
